// File: rtl/stopwatch_bcd_core.sv
// stopwatch_bcd_core: BCD MM:SS stopwatch driven by a divided-clock level.
// tick_in, start_stop, clear and lap are sampled in the clk domain and
// their rising edges are used as one-cycle enables; tick_in is never a clock.
// Optional feature macro: STOPWATCH_LAP_EN (lap display freeze with snapshot).
module stopwatch_bcd_core #(
    parameter int MAX_MINUTES = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] min_u,
    output logic [3:0] min_t,
    output logic       running,
    output logic       frozen,
    output logic       rollover
);

    localparam logic [3:0] MAX_MT = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MAX_MU = 4'(MAX_MINUTES % 10);

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
    } bcd_t;

    // One-step BCD increment of MM:SS; wrap at MAX_MINUTES:59 is handled by the caller.
    function automatic bcd_t bcd_inc(input bcd_t c);
        bcd_t n;
        n = c;
        if (c.su != 4'd9) begin
            n.su = c.su + 4'd1;
        end else begin
            n.su = 4'd0;
            if (c.st != 4'd5) begin
                n.st = c.st + 4'd1;
            end else begin
                n.st = 4'd0;
                if (c.mu != 4'd9) begin
                    n.mu = c.mu + 4'd1;
                end else begin
                    n.mu = 4'd0;
                    n.mt = c.mt + 4'd1;
                end
            end
        end
        return n;
    endfunction

    state_t state_q, state_d;
    bcd_t   cnt_q, cnt_d;
    logic   roll_q, roll_d;
    logic   run_q;
    logic   tick_prev_q, ss_prev_q, clr_prev_q;

    logic ev_tick, ev_ss, ev_clear, at_max;

    assign ev_tick  = tick_in & ~tick_prev_q;
    assign ev_ss    = start_stop & ~ss_prev_q;
    assign ev_clear = clear & ~clr_prev_q;
    assign at_max   = (cnt_q.mt == MAX_MT) && (cnt_q.mu == MAX_MU) &&
                      (cnt_q.st == 4'd5) && (cnt_q.su == 4'd9);

    // Next state and count: clear beats start_stop beats tick; tick uses the pre-transition state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        roll_d  = 1'b0;
        if (ev_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            if ((state_q == RUNNING) && ev_tick) begin
                if (at_max) begin
                    cnt_d  = '0;
                    roll_d = 1'b1;
                end else begin
                    cnt_d = bcd_inc(cnt_q);
                end
            end
            if (ev_ss) begin
                case (state_q)
                    IDLE:    state_d = RUNNING;
                    RUNNING: state_d = PAUSED;
                    default: state_d = RUNNING;
                endcase
            end
        end
    end

    // State, count, status and edge-detect registers; buttons reset high so a held button is not an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            roll_q      <= 1'b0;
            run_q       <= 1'b0;
            tick_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            clr_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            roll_q      <= roll_d;
            run_q       <= (state_d == RUNNING);
            tick_prev_q <= tick_in;
            ss_prev_q   <= start_stop;
            clr_prev_q  <= clear;
        end
    end

    assign running  = run_q;
    assign rollover = roll_q;

`ifdef STOPWATCH_LAP_EN
    logic lap_prev_q;
    logic frz_q, frz_d;
    bcd_t disp_q, disp_d;
    logic ev_lap;

    assign ev_lap = lap & ~lap_prev_q;

    // Freeze toggle; the display follows the live count except while staying frozen.
    always_comb begin
        frz_d = frz_q;
        if (ev_clear) begin
            frz_d = 1'b0;
        end else if (ev_lap && (state_q != IDLE)) begin
            frz_d = ~frz_q;
        end
        disp_d = (frz_q && frz_d) ? disp_q : cnt_d;
    end

    // Display snapshot and freeze flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_prev_q <= 1'b1;
            frz_q      <= 1'b0;
            disp_q     <= '0;
        end else begin
            lap_prev_q <= lap;
            frz_q      <= frz_d;
            disp_q     <= disp_d;
        end
    end

    assign frozen = frz_q;
    assign min_t  = disp_q.mt;
    assign min_u  = disp_q.mu;
    assign sec_t  = disp_q.st;
    assign sec_u  = disp_q.su;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign frozen     = 1'b0;
    assign min_t      = cnt_q.mt;
    assign min_u      = cnt_q.mu;
    assign sec_t      = cnt_q.st;
    assign sec_u      = cnt_q.su;
`endif

endmodule

// File: doc/stopwatch_bcd_core.md
Name: stopwatch_bcd_core

Overview:
- BCD MM:SS stopwatch counter. It sits directly downstream of the 1 Hz clock divider and consumes that divider's divided-clock output as a level input, `tick_in`, sampled in the `clk` domain.
- It never uses `tick_in` as a clock. The rising edge of `tick_in` is detected and used as a one-cycle count enable.
- Start/stop and clear controls come from debounced, clk-synchronous button levels.
- The outputs are four BCD digits for the display/multiplexer stage, plus status.

Parameters:
- MAX_MINUTES, 59: highest minute value before wrap; legal range 1..99.

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  asynchronous, active-high reset
- tick_in  input  1  divided-clock level from the divider; each rising edge counts one second
- start_stop  input  1  debounced level; each rising edge toggles run/pause
- clear  input  1  debounced level; rising edge zeroes the count and returns to IDLE
- lap  input  1  debounced level; rising edge toggles display freeze (LAP_EN only)
- sec_u  output  4  seconds units, BCD 0..9
- sec_t  output  4  seconds tens, BCD 0..5
- min_u  output  4  minutes units, BCD 0..9
- min_t  output  4  minutes tens, BCD 0..9
- running  output  1  high while in state RUNNING
- frozen  output  1  high while the display is held by lap
- rollover  output  1  one-clk pulse when the count wraps from MAX_MINUTES:59 to 00:00

Behaviour:
- Reset, asynchronous:
  - digits = 0; state = IDLE; running, frozen, rollover = 0.
  - tick edge register = 0.
  - Button edge registers = 1, so a button held through reset produces no event.
- Edge detection:
  - `ev_x = x & ~x_prev`, with `x_prev` registered every clk.
  - An event is acted on at the same clk edge where it is sampled.
  - Count latency is one clk edge after `tick_in` rises.
- States:
  - IDLE: count 00:00; ticks ignored. `ev_start_stop` → RUNNING.
  - RUNNING: each `ev_tick` increments the count. `ev_start_stop` → PAUSED.
  - PAUSED: ticks ignored. `ev_start_stop` → RUNNING.
  - Any state: `ev_clear` → IDLE with digits = 0.
- Priority, for simultaneous events:
  - clear > start_stop > tick.
  - On the same edge as a start_stop event, tick handling follows the state *before* the transition:
    - RUNNING + tick + start_stop: the tick is counted, then the state becomes PAUSED.
    - PAUSED + tick + start_stop: the tick is not counted, then the state becomes RUNNING.
  - clear + tick: digits = 0, no increment, no rollover.
- Increment chain (BCD):
  - `sec_u` 9→0 carries into `sec_t`.
  - `sec_t` 5→0 carries into minutes.
  - Minutes increment as two BCD digits.
  - At minutes == MAX_MINUTES and seconds == 59, the next tick sets all digits to 0 and pulses `rollover` for exactly one clk. Counting continues in RUNNING.
- Digit legality: digits never hold a non-BCD value.
- Register timing: all outputs are registered. `running` is asserted exactly while state == RUNNING.
- Mid-operation reset: immediate return to the reset values; no event is generated on reset release.

Optional Feature:
- Macro: `STOPWATCH_LAP_EN`.
- Defined:
  - `ev_lap` while RUNNING or PAUSED toggles `frozen`.
  - While `frozen` = 1, the digit outputs show a snapshot taken at the freeze edge, while the internal count keeps advancing.
  - Unfreezing shows the live count at that same edge.
  - `ev_clear` forces `frozen` = 0.
  - `ev_lap` in IDLE is ignored.
- Not defined:
  - `lap` is ignored; `frozen` is tied 0.
  - Digit outputs are always the live count.
  - No snapshot registers are built.

Test Plan:
- Reset released with `start_stop` held high:
  - no start; state stays IDLE and outputs read 00:00.
  - Release, then press: `running` = 1 one clk after the press edge.
- RUNNING, 10 `tick_in` rising edges:
  - reads 00:10, i.e. `sec_t` = 1, `sec_u` = 0.
  - Each increment lands one clk after the `tick_in` rise.
  - A `tick_in` held high for 1000 clk counts once.
- MAX_MINUTES=1, run to 01:59, one tick:
  - reads 00:00.
  - `rollover` is high for exactly 1 clk.
  - `running` stays 1.
- RUNNING at 00:05, `start_stop` and `tick_in` rising on the same clk:
  - reads 00:06 and state is PAUSED.
  - 3 further ticks: still 00:06.
  - Press again, then one tick: 00:07.
- At 00:42 RUNNING, `clear` and `tick_in` rising on the same clk:
  - reads 00:00, state IDLE, `rollover` = 0.
  - Subsequent ticks are ignored.
- STOPWATCH_LAP_EN, RUNNING at 00:20:
  - press lap: outputs hold 00:20 and `frozen` = 1.
  - 5 ticks: still 00:20.
  - Press lap: outputs show 00:25.
  - Rebuild without the macro: a lap press has no effect.
